// File: rtl/result_collector.sv
// Collects results from an arithmetic unit into a small circular buffer and
// forwards them in order to a downstream FIFO; supports a flush/drain handshake.
module result_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  complete,
    input  logic [DATA_WIDTH-1:0] sum,
    output logic                  out_rd_en,
    input  logic                  out_full,
    output logic                  out_wr_en,
    output logic [DATA_WIDTH-1:0] out_din,
    input  logic                  flush,
    output logic                  flush_done,
    output logic [15:0]           result_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [15:0]           result_count_q, result_count_d;
    logic                  push, pop;

    always_comb begin
        // Accept is gated by current occupancy only, so a full buffer refuses
        // a result even when a pop frees a slot in the same cycle.
        push = complete && (state_q == ST_RUN) && (count_q < CNT_W'(DEPTH)) && !reset;
        pop  = (count_q != '0) && !out_full && !reset;

        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        result_count_d = result_count_q;
        state_d        = state_q;

        if (push) begin
            mem_d[wr_ptr_q] = sum;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            result_count_d  = result_count_q + 16'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_RUN:   if (flush) state_d = ST_DRAIN;
            ST_DRAIN: if (count_d == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_RUN;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            result_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            result_count_q <= result_count_d;
            mem_q          <= mem_d;
        end
    end

    assign out_rd_en    = push;
    assign out_wr_en    = pop;
    assign out_din      = reset ? '0 : mem_q[rd_ptr_q];
    assign flush_done   = (state_q == ST_DONE) && !reset;
    assign result_count = result_count_q;

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: result and output data width.
REQ-002 SHALL have parameter DEPTH, default 4 (power of two, >=2): internal buffer entries.
REQ-003 SHALL have port clock, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port complete, input, 1: the arithmetic unit holds a valid result.
REQ-006 SHALL have port sum, input, DATA_WIDTH: the arithmetic unit result, valid while complete=1.
REQ-007 SHALL have port out_rd_en, output, 1: result accepted this cycle; goes to the unit.
REQ-008 SHALL have port out_full, input, 1: the downstream FIFO is full.
REQ-009 SHALL have port out_wr_en, output, 1: write strobe to the downstream FIFO.
REQ-010 SHALL have port out_din, output, DATA_WIDTH: data to the downstream FIFO.
REQ-011 SHALL have port flush, input, 1: request to stop accepting and drain; level-sampled.
REQ-012 SHALL have port flush_done, output, 1: one-cycle pulse when the drain finishes.
REQ-013 SHALL have port result_count, output, 16: results accepted since reset.

Function
REQ-014 SHALL implement a DEPTH-entry circular buffer with read/write pointers and an occupancy count of 0..DEPTH.
REQ-015 SHALL drive out_rd_en combinationally as complete AND state==RUN AND occupancy<DEPTH.
REQ-016 SHALL write sum into the buffer tail at the rising edge where complete=1 and out_rd_en=1.
REQ-017 SHALL drive out_wr_en combinationally as occupancy>0 AND NOT out_full.
REQ-018 SHALL drive out_din combinationally from the buffer head; it is don't-care when empty.
REQ-019 SHALL advance the head pointer at each edge where out_wr_en=1.
REQ-020 SHALL allow a push and a pop in the same cycle; occupancy is then unchanged.
REQ-021 SHALL NOT accept a result when occupancy==DEPTH, even if a pop occurs that cycle.
REQ-022 SHALL wrap both pointers modulo DEPTH.
REQ-023 SHALL produce results in arrival order; first result appears on out_din 1 cycle after acceptance (latency 1 when downstream not full).
REQ-024 SHALL increment result_count by 1 per accepted result, wrapping 16'hFFFF -> 0.
REQ-025 SHALL implement states RUN, DRAIN, DONE.
REQ-026 SHALL move RUN -> DRAIN on an edge where flush=1; a result accepted in that same cycle is still stored.
REQ-027 SHALL keep out_rd_en=0 in DRAIN and DONE while output draining continues normally.
REQ-028 SHALL move DRAIN -> DONE on the edge where occupancy becomes 0, or immediately if already 0.
REQ-029 SHALL assert flush_done=1 for exactly the one cycle spent in DONE, then return to RUN.
REQ-030 SHALL ignore flush while in DRAIN or DONE; a flush still high in RUN starts a new drain.
REQ-031 SHALL never change buffer contents or pointers when out_full=1 and there is no accept.

Reset
REQ-032 SHALL, at an edge with reset=1, set occupancy 0, both pointers 0, result_count 0 and state RUN, discarding buffered data.
REQ-033 SHALL hold out_rd_en=0, out_wr_en=0 and flush_done=0 while reset=1, regardless of other inputs.
REQ-034 SHALL have out_din reset to 0.
REQ-035 SHALL treat reset mid-DRAIN like any other reset: no flush_done pulse is produced.

Verification
REQ-036 Bench SHALL cover this case: complete=1 with sum=5, then 7, then 9, out_full=0 -> out_rd_en=1 each cycle; out_din 5,7,9 with out_wr_en one cycle later; result_count=3.
REQ-037 Bench SHALL cover this case: out_full=1 with 4 results offered -> 4 accepted; 5th cycle out_rd_en=0. Then out_full=0 -> 4 writes in order, then out_rd_en=1 again.
REQ-038 Bench SHALL cover this case: buffer full, out_full=0, complete=1 -> pop occurs, push refused that cycle, push accepted on the next cycle.
REQ-039 Bench SHALL cover this case: 2 results buffered, flush pulsed with out_full=0 -> out_rd_en=0 from the next cycle, 2 writes, then flush_done high for exactly 1 cycle, then RUN.
REQ-040 Bench SHALL cover this case: result_count preset by 65535 accepts, then 1 more -> result_count=0.
REQ-041 Bench SHALL cover this case: reset asserted in DRAIN with 3 entries -> next cycle occupancy 0, out_wr_en=0, no flush_done pulse, state RUN.
